// File: rtl/rv32i_rf_wb_arbiter.sv
// Register-file write-back arbiter for an RV32I core.
// Round-robin grant across NREQ write-back sources, registered write port
// toward the register file, and a saturating counter of contended cycles.
module rv32i_rf_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0][4:0]   req_rd,
    input  logic [NREQ-1:0][31:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   stall,
    output logic                   rf_wen,
    output logic [4:0]             rf_rd,
    output logic [31:0]            rf_wdata,
    output logic [CNT_W-1:0]       conflict_cnt
);

    localparam int              PTR_W  = $clog2(NREQ);
    localparam logic [PTR_W:0]  NREQ_L = (PTR_W+1)'(NREQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] nxt_ptr;
    logic             gnt_any;
    logic [4:0]       gnt_rd;
    logic [31:0]      gnt_data;
    logic             multi_vld;
    logic             conflict;

    // Rotating-priority search starting at rr_ptr; suppressed by stall and reset.
    always_comb begin
        logic           found;
        logic [PTR_W:0] cand;
        req_ready = '0;
        found     = 1'b0;
        cand      = '0;
        if (!RST && !stall) begin
            for (int i = 0; i < NREQ; i++) begin
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
                if (cand >= NREQ_L)
                    cand = cand - NREQ_L;
                if (!found && req_valid[cand[PTR_W-1:0]]) begin
                    req_ready[cand[PTR_W-1:0]] = 1'b1;
                    found                      = 1'b1;
                end
            end
        end
    end

    // Select the granted requester's payload and the pointer that follows it.
    always_comb begin
        gnt_rd   = '0;
        gnt_data = '0;
        nxt_ptr  = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
                gnt_rd   = req_rd[k];
                gnt_data = req_data[k];
                nxt_ptr  = (k == NREQ-1) ? '0 : PTR_W'(k+1);
            end
        end
    end

    assign gnt_any   = |req_ready;
    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign multi_vld = |(req_valid & (req_valid - 1'b1));
    assign conflict  = multi_vld && !stall;

    // Pointer advances past the winner; holds when nothing is granted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rr_ptr <= '0;
        else if (gnt_any)
            rr_ptr <= nxt_ptr;
    end

    // Registered write port; writes to x0 are granted but never enabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= gnt_any && (gnt_rd != 5'd0);
            if (gnt_any) begin
                rf_rd    <= gnt_rd;
                rf_wdata <= gnt_data;
            end
        end
    end

    // Saturating count of cycles where several sources compete.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            conflict_cnt <= '0;
        else if (conflict && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 1'b1;
    end

endmodule

// File: doc/rv32i_rf_wb_arbiter.md
RV32I_RF_WB_ARBITER -- requirements
Module: rv32i_rf_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of write-back requesters (0 = execute, 1 = load return, 2 = multicycle mul/div); legal range 2..4.
REQ-002 Parameter CNT_W, default 16, width of the conflict counter.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NREQ  requester i has a register write pending.
REQ-006 req_rd  input  NREQ x 5  destination register index per requester.
REQ-007 req_data  input  NREQ x 32  write data per requester.
REQ-008 req_ready  output  NREQ  one-hot grant; the handshake for requester i completes when req_valid[i] and req_ready[i] are both high.
REQ-009 stall  input  1  when high, no grant is issued.
REQ-010 rf_wen  output  1  drives the register file write enable.
REQ-011 rf_rd  output  5  drives the register file rd.
REQ-012 rf_wdata  output  32  drives the register file w_data.
REQ-013 conflict_cnt  output  CNT_W  saturating count of cycles with more than one req_valid high and stall low.

Function
REQ-014 req_ready SHALL be combinational from req_valid, stall and the rotation pointer, with at most one bit high.
REQ-015 The block SHALL keep a rotation pointer rr_ptr (0..NREQ-1) naming the highest-priority requester.
REQ-016 Grant search SHALL run rr_ptr, rr_ptr+1, ... modulo NREQ; the first requester with req_valid high is granted.
REQ-017 On a grant to requester k, rr_ptr SHALL become (k+1) mod NREQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-018 With stall high, req_ready SHALL be all zero, rr_ptr SHALL hold, and rf_wen SHALL be 0 at the next edge.
REQ-019 The output stage SHALL be registered: a grant in cycle N puts rf_rd/rf_wdata for requester k in cycle N+1, so latency is exactly 1 cycle.
REQ-020 rf_wen in cycle N+1 SHALL be 1 iff a grant occurred in cycle N and the granted req_rd is nonzero.
REQ-021 A granted write to x0 SHALL complete its handshake, advance rr_ptr, and leave rf_wen 0.
REQ-022 With no grant in cycle N, rf_wen SHALL be 0 in cycle N+1 and rf_rd/rf_wdata SHALL hold their previous values.
REQ-023 The output stage never back-pressures, because the register file write always completes, so back-to-back grants every cycle SHALL be sustained.
REQ-024 Requesters SHALL hold req_rd/req_data stable while valid and not ready; the arbiter SHALL NOT latch inputs before grant.
REQ-025 A requester may drop req_valid before grant; the arbiter SHALL then simply not grant it.
REQ-026 When two requesters target the same rd, writes SHALL occur in grant order, and the later grant's data is the final value.
REQ-027 conflict_cnt SHALL increment by 1 on each qualifying cycle and saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-028 While RST is high: rr_ptr=0, rf_wen=0, rf_rd=0, rf_wdata=0, conflict_cnt=0, and req_ready all zero, regardless of req_valid.
REQ-029 Reset asserted mid-operation SHALL clear the output stage immediately, without waiting for an edge; a write granted in the cycle before reset SHALL NOT reach the register file.
REQ-030 After RST deasserts, the first grant SHALL follow REQ-016 with rr_ptr=0.

Verification
REQ-031 Reset, then req_valid=3'b111 held for 3 cycles, stall=0 -> grants 0, 1, 2 on consecutive cycles; rf_wen=1 from cycle 2; conflict_cnt=3.
REQ-032 Only req 2 valid (rd=5, data=0xDEADBEEF) -> req_ready=3'b100 the same cycle; next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF; rr_ptr=0.
REQ-033 req 1 valid with rd=0 -> handshake completes; next cycle rf_wen=0; rr_ptr becomes 2.
REQ-034 stall=1 with req_valid=3'b011 for 4 cycles, then stall=0 -> no ready and rf_wen=0 during the stall; conflict_cnt unchanged; req 0 granted first after release.
REQ-035 RST pulsed asynchronously mid-cycle right after a grant with rd=7 -> rf_wen=0 immediately and stays 0 at the next edge; rr_ptr=0.
REQ-036 CNT_W=2, all requesters valid for 6 cycles -> conflict_cnt reads 1, 2, 3, 3, 3, 3.
